// File: rtl/ysyx_25040111_icache_sa.sv
// N-way set-associative instruction cache with round-robin replacement, burst or
// single-beat refill, single-cycle flush and saturating hit/miss counters.
module ysyx_25040111_icache_sa #(
    parameter int unsigned WAYS_LOG2  = 1,
    parameter int unsigned SETS_LOG2  = 4,
    parameter int unsigned BLOCK_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] data,
    input  logic        flush,
    input  logic        rburst,
    output logic        rstart,
    output logic [31:0] raddr,
    output logic [7:0]  rlen,
    input  logic        rok,
    input  logic [31:0] rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned WAYS   = 1 << WAYS_LOG2;
    localparam int unsigned SETS   = 1 << SETS_LOG2;
    localparam int unsigned WORDS  = 1 << (BLOCK_LOG2 - 2);
    localparam int unsigned TAG_W  = 32 - BLOCK_LOG2 - SETS_LOG2;
    localparam int unsigned WAY_W  = (WAYS_LOG2 > 0) ? WAYS_LOG2 : 1;
    localparam int unsigned SET_W  = (SETS_LOG2 > 0) ? SETS_LOG2 : 1;
    localparam int unsigned WORD_W = (BLOCK_LOG2 > 2) ? (BLOCK_LOG2 - 2) : 1;
    localparam int unsigned BC_W   = BLOCK_LOG2 - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      mem_q   [WAYS][SETS][WORDS];
    logic [WAY_W-1:0] ptr_q   [SETS];

    logic              rburst_q;
    logic              flushed_q;
    logic [SET_W-1:0]  ref_set;
    logic [TAG_W-1:0]  ref_tag;
    logic [WORD_W-1:0] ref_word;
    logic [WAY_W-1:0]  victim_q;
    logic [BC_W-1:0]   beat_cnt;
    logic [31:0]       fill_word;
    logic              ready_q;
    logic [31:0]       data_q;
    logic              rstart_q;
    logic [31:0]       raddr_q;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       miss_cnt_q;

    logic [SET_W-1:0]  lk_set;
    logic [TAG_W-1:0]  lk_tag;
    logic [WORD_W-1:0] lk_word;
    logic [WORD_W-1:0] beat_word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              accept_hit;
    logic              accept_miss;
    logic              beat_fire;
    logic              last_beat;

    // Shifts and masks keep the slices legal for degenerate geometries (1-word lines).
    assign lk_set    = SET_W'((addr >> BLOCK_LOG2) & (SETS - 1));
    assign lk_tag    = TAG_W'(addr >> (BLOCK_LOG2 + SETS_LOG2));
    assign lk_word   = WORD_W'((addr >> 2) & (WORDS - 1));
    assign beat_word = WORD_W'(32'(beat_cnt) & (WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[w][lk_set] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        beat_fire   = 1'b0;
        last_beat   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    if (hit) begin
                        accept_hit = 1'b1;
                    end else begin
                        accept_miss = 1'b1;
                        state_d     = REFILL;
                    end
                end
            end
            REFILL: begin
                if (rok) begin
                    beat_fire = 1'b1;
                    if (beat_cnt == BC_W'(WORDS - 1)) begin
                        last_beat = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            rburst_q   <= 1'b0;
            flushed_q  <= 1'b0;
            ref_set    <= '0;
            ref_tag    <= '0;
            ref_word   <= '0;
            victim_q   <= '0;
            beat_cnt   <= '0;
            fill_word  <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            rstart_q   <= 1'b0;
            raddr_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            ready_q  <= 1'b0;
            rstart_q <= 1'b0;

            if (flush) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end

            if (accept_hit) begin
                ready_q <= 1'b1;
                data_q  <= mem_q[hit_way][lk_set][lk_word];
                if (hit_cnt_q != '1) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end

            // The victim is invalidated up front so a partially overwritten line can never hit.
            if (accept_miss) begin
                rburst_q                        <= rburst;
                flushed_q                       <= 1'b0;
                ref_set                         <= lk_set;
                ref_tag                         <= lk_tag;
                ref_word                        <= lk_word;
                victim_q                        <= ptr_q[lk_set];
                valid_q[lk_set][ptr_q[lk_set]]  <= 1'b0;
                beat_cnt                        <= '0;
                rstart_q                        <= 1'b1;
                raddr_q                         <= addr & ~(32'(1 << BLOCK_LOG2) - 32'd1);
            end

            if ((state_q == REFILL) && flush) begin
                flushed_q <= 1'b1;
            end

            if (beat_fire) begin
                beat_cnt <= beat_cnt + BC_W'(1);
                if (beat_word == ref_word) begin
                    fill_word <= rdata;
                end
                if (!last_beat && !rburst_q) begin
                    rstart_q <= 1'b1;
                    raddr_q  <= raddr_q + 32'd4;
                end
            end

            if (state_q == DONE) begin
                if (!flushed_q && !flush) begin
                    valid_q[ref_set][victim_q] <= 1'b1;
                end
                ptr_q[ref_set] <= WAY_W'((32'(ptr_q[ref_set]) + 32'd1) % WAYS);
                ready_q        <= 1'b1;
                data_q         <= fill_word;
                if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (beat_fire) begin
            mem_q[victim_q][ref_set][beat_word] <= rdata;
        end
        if (state_q == DONE) begin
            tag_q[victim_q][ref_set] <= ref_tag;
        end
    end

    assign ready    = ready_q;
    assign data     = data_q;
    assign rstart   = rstart_q;
    assign raddr    = raddr_q;
    assign rlen     = rburst_q ? 8'(WORDS - 1) : 8'd0;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_25040111_icache_sa.sv
// Directed bench for the set-associative icache: table of fetches against a bus
// memory model, plus flush and mid-refill reset sequences.
module tb_ysyx_25040111_icache_sa;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        flush;
    logic        rburst;
    logic        rstart;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic        rok;
    logic [31:0] rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int ncmp  = 0;
    int nfail = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    ysyx_25040111_icache_sa #(
        .WAYS_LOG2 (1),
        .SETS_LOG2 (4),
        .BLOCK_LOG2(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .valid   (valid),
        .ready   (ready),
        .data    (data),
        .flush   (flush),
        .rburst  (rburst),
        .rstart  (rstart),
        .raddr   (raddr),
        .rlen    (rlen),
        .rok     (rok),
        .rdata   (rdata),
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic        rb;
        logic        hit;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one fetch, acts as the bus slave, returns data, rstart count and latency.
    task automatic access(input logic [31:0] a, input logic rb, input int flush_cyc,
                          output logic [31:0] got, output int starts, output int lat);
        logic [31:0] base;
        logic [31:0] baddr;
        int          beats_left;
        int          cyc;
        bit          done;
        base       = a & ~32'hF;
        baddr      = '0;
        beats_left = 0;
        cyc        = 0;
        done       = 0;
        got        = '0;
        starts     = 0;
        addr       = a;
        rburst     = rb;
        valid      = 1'b1;
        while (!done && cyc < 100) begin
            flush = (cyc == flush_cyc);
            @(posedge clock);
            #1;
            cyc++;
            rok   = 1'b0;
            flush = 1'b0;
            if (ready) begin
                got   = data;
                done  = 1;
                valid = 1'b0;
            end else begin
                if (rstart) begin
                    starts++;
                    chk("raddr", raddr, rb ? base : base + 32'(4 * (starts - 1)));
                    chk("rlen", 32'(rlen), rb ? 32'd3 : 32'd0);
                    beats_left = rb ? 4 : 1;
                    baddr      = raddr;
                end
                if (beats_left > 0) begin
                    rok        = 1'b1;
                    rdata      = memf(baddr);
                    baddr      = baddr + 32'd4;
                    beats_left--;
                end
            end
        end
        if (!done) begin
            ncmp++;
            nfail++;
            $display("FAIL timeout: no ready for addr %h after %0d cycles", a, cyc);
            valid = 1'b0;
        end
        lat = cyc;
    endtask

    task automatic run(input string nm, input logic [31:0] a, input logic rb, input int flush_cyc,
                       input bit exp_hit, input int exp_lat);
        logic [31:0] got;
        int          starts;
        int          lat;
        access(a, rb, flush_cyc, got, starts, lat);
        chk({nm, "_data"}, got, memf(a));
        chk({nm, "_rstarts"}, 32'(starts), exp_hit ? 32'd0 : (rb ? 32'd1 : 32'd4));
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_hit) exp_hits++;
        else         exp_misses++;
    endtask

    initial begin
        vecs[0]  = '{32'h8000_0014, 1'b1, 1'b0};
        vecs[1]  = '{32'h8000_0018, 1'b1, 1'b1};
        vecs[2]  = '{32'h8000_0100, 1'b0, 1'b0};
        vecs[3]  = '{32'h8000_010C, 1'b1, 1'b1};
        vecs[4]  = '{32'h8000_0110, 1'b1, 1'b0};
        vecs[5]  = '{32'h8000_0210, 1'b0, 1'b0};
        vecs[6]  = '{32'h8000_0114, 1'b1, 1'b1};
        vecs[7]  = '{32'h8000_0010, 1'b1, 1'b0};
        vecs[8]  = '{32'h8000_021C, 1'b1, 1'b1};
        vecs[9]  = '{32'h8000_0110, 1'b1, 1'b0};
        vecs[10] = '{32'h8000_00F0, 1'b1, 1'b0};
        vecs[11] = '{32'h8000_00FC, 1'b0, 1'b1};
        vecs[12] = '{32'h8000_0010, 1'b1, 1'b1};

        reset  = 1'b0;
        addr   = '0;
        valid  = 1'b0;
        flush  = 1'b0;
        rburst = 1'b0;
        rok    = 1'b0;
        rdata  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_rstart", 32'(rstart), 32'd0);
        chk("rst_raddr", raddr, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) begin
            run($sformatf("vec%0d", i), vecs[i].a, vecs[i].rb, -1, vecs[i].hit,
                vecs[i].hit ? 1 : 6);
        end
        chk("tbl_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("tbl_miss_cnt", miss_cnt, 32'(exp_misses));
        repeat (2) @(posedge clock);
        #1;
        chk("data_held", data, memf(32'h8000_0010));
        chk("idle_no_ready", 32'(ready), 32'd0);

        // Flush during refill, flush in idle, flush concurrent with a request.
        run("fl_refill", 32'h8000_0040, 1'b1, 2, 1'b0, 6);
        run("fl_again", 32'h8000_0040, 1'b1, -1, 1'b0, 6);
        run("fl_hit", 32'h8000_0044, 1'b1, -1, 1'b1, 1);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        run("fl_idle", 32'h8000_0044, 1'b1, -1, 1'b0, 6);
        run("fl_hit2", 32'h8000_0048, 1'b0, -1, 1'b1, 1);
        run("fl_concur", 32'h8000_0048, 1'b1, 0, 1'b0, 7);
        chk("fl_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("fl_miss_cnt", miss_cnt, 32'(exp_misses));

        // Reset one cycle after the second beat of a burst refill.
        addr   = 32'h8000_0084;
        rburst = 1'b1;
        valid  = 1'b1;
        @(posedge clock);
        #1;
        chk("mr_rstart", 32'(rstart), 32'd1);
        rok   = 1'b1;
        rdata = memf(32'h8000_0080);
        @(posedge clock);
        #1;
        rdata = memf(32'h8000_0084);
        @(posedge clock);
        #1;
        rdata = memf(32'h8000_0088);
        @(posedge clock);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        rdata = memf(32'h8000_008C);
        #1;
        chk("mr_ready", 32'(ready), 32'd0);
        chk("mr_data", data, 32'd0);
        chk("mr_rstart0", 32'(rstart), 32'd0);
        chk("mr_raddr", raddr, 32'd0);
        chk("mr_hit_cnt", hit_cnt, 32'd0);
        chk("mr_miss_cnt", miss_cnt, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clock);
        #1;
        rok = 1'b0;
        chk("stray_ready", 32'(ready), 32'd0);
        chk("stray_rstart", 32'(rstart), 32'd0);
        run("mr_line", 32'h8000_0084, 1'b1, -1, 1'b0, 6);
        run("mr_old", 32'h8000_0018, 1'b1, -1, 1'b0, 6);
        run("mr_hit", 32'h8000_0088, 1'b1, -1, 1'b1, 1);
        chk("mr_end_hit_cnt", hit_cnt, 32'(exp_hits));
        chk("mr_end_miss_cnt", miss_cnt, 32'(exp_misses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
